// File: rtl/dbg_cnt_scan.sv
// -----------------------------------------------------------------------------
// dbg_cnt_scan
//
// Scan controller and register-port arbiter for the debug pulse-width counter
// block. The counter block's byte-wide host register port is shared between
// the external host and an internal sequencer. The sequencer periodically
// reads all eight 12-bit width-history slots (low byte, then high nibble),
// streams each one out as a valid/ready record, and can optionally clear the
// counter block once a full scan has been delivered.
//
// The host always has priority. In any cycle where the host asserts a read or
// write enable, its enables and data pass straight through to the counter
// block. A sequencer access that collides with the host is held and retried
// in the following cycle.
//
// Ports:
//   CLK         clock
//   RST_N       asynchronous active-low reset
//   iEN         periodic scanning enable (level)
//   iPERIOD     idle cycles between scans (0 behaves as 1)
//   iCLR_AFTER  write the clear command after each completed scan
//   iH_WE_BIT   host write enables (one-hot)
//   iH_RE_BIT   host read enables (one-hot)
//   iH_DATA     host write data
//   oH_RD       host read data (zero when the host is not accessing)
//   oWE_BIT     write enables to the counter block
//   oRE_BIT     read enables to the counter block
//   oDATA       write data to the counter block
//   iRD         combinational read data from the counter block
//   oVALID      record valid
//   iREADY      record accepted
//   oIDX        slot index (0-3 high-level widths, 4-7 low-level widths)
//   oCNT        slot value
//   oBUSY       scan in progress
//   oSCANS      completed-scan count (wraps)
// -----------------------------------------------------------------------------
module dbg_cnt_scan #(
    parameter int WE_WIDTH = 8,
    parameter int RE_WIDTH = 16,
    parameter int C_CNT_WH = 12,
    parameter int PERIOD_W = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic                iEN,
    input  logic [PERIOD_W-1:0] iPERIOD,
    input  logic                iCLR_AFTER,
    input  logic [WE_WIDTH-1:0] iH_WE_BIT,
    input  logic [RE_WIDTH-1:0] iH_RE_BIT,
    input  logic [7:0]          iH_DATA,
    output logic [7:0]          oH_RD,
    output logic [WE_WIDTH-1:0] oWE_BIT,
    output logic [RE_WIDTH-1:0] oRE_BIT,
    output logic [7:0]          oDATA,
    input  logic [7:0]          iRD,
    output logic                oVALID,
    input  logic                iREADY,
    output logic [2:0]          oIDX,
    output logic [C_CNT_WH-1:0] oCNT,
    output logic                oBUSY,
    output logic [7:0]          oSCANS
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_RD_L = 3'd2,
        ST_RD_H = 3'd3,
        ST_PUSH = 3'd4,
        ST_CLR  = 3'd5
    } state_t;

    localparam logic [RE_WIDTH-1:0] RE_ONE    = {{(RE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WE_WIDTH-1:0] WE_ONE    = {{(WE_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] TIMER_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};

    state_t                state_r;
    state_t                state_nxt_s;
    logic [2:0]            slot_r;
    logic [2:0]            slot_nxt_s;
    logic [PERIOD_W-1:0]   timer_r;
    logic [PERIOD_W-1:0]   timer_nxt_s;
    logic [C_CNT_WH-1:0]   cnt_r;
    logic [C_CNT_WH-1:0]   cnt_nxt_s;
    logic [7:0]            scans_r;
    logic [7:0]            scans_nxt_s;

    logic                  host_act_s;
    logic [WE_WIDTH-1:0]   seq_we_s;
    logic [RE_WIDTH-1:0]   seq_re_s;
    logic [7:0]            seq_data_s;
    logic                  valid_s;
    logic                  busy_s;

    assign host_act_s = (|iH_WE_BIT) | (|iH_RE_BIT);

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath registers: slot pointer, interval timer, captured value, scan count
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            slot_r  <= 3'd0;
            timer_r <= {PERIOD_W{1'b0}};
            cnt_r   <= {C_CNT_WH{1'b0}};
            scans_r <= 8'd0;
        end else begin
            slot_r  <= slot_nxt_s;
            timer_r <= timer_nxt_s;
            cnt_r   <= cnt_nxt_s;
            scans_r <= scans_nxt_s;
        end
    end

    // Next-state and datapath update logic
    always_comb begin
        state_nxt_s = state_r;
        slot_nxt_s  = slot_r;
        timer_nxt_s = timer_r;
        cnt_nxt_s   = cnt_r;
        scans_nxt_s = scans_r;
        case (state_r)
            ST_IDLE: begin
                if (iEN) begin
                    timer_nxt_s = iPERIOD;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!iEN) begin
                    state_nxt_s = ST_IDLE;
                end else if (timer_r <= TIMER_ONE) begin
                    // A zero period falls in here too, so the wait is never shorter than one cycle.
                    slot_nxt_s  = 3'd0;
                    state_nxt_s = ST_RD_L;
                end else begin
                    timer_nxt_s = timer_r - TIMER_ONE;
                end
            end
            ST_RD_L: begin
                if (host_act_s) begin
                    state_nxt_s = ST_RD_L;
                end else begin
                    cnt_nxt_s[7:0] = iRD;
                    state_nxt_s    = ST_RD_H;
                end
            end
            ST_RD_H: begin
                if (host_act_s) begin
                    state_nxt_s = ST_RD_H;
                end else begin
                    cnt_nxt_s[C_CNT_WH-1:8] = iRD[C_CNT_WH-9:0];
                    state_nxt_s             = ST_PUSH;
                end
            end
            ST_PUSH: begin
                if (iREADY) begin
                    if (slot_r != 3'd7) begin
                        slot_nxt_s  = slot_r + 3'd1;
                        state_nxt_s = ST_RD_L;
                    end else begin
                        scans_nxt_s = scans_r + 8'd1;
                        if (iCLR_AFTER) begin
                            state_nxt_s = ST_CLR;
                        end else if (iEN) begin
                            timer_nxt_s = iPERIOD;
                            state_nxt_s = ST_WAIT;
                        end else begin
                            state_nxt_s = ST_IDLE;
                        end
                    end
                end else begin
                    state_nxt_s = ST_PUSH;
                end
            end
            ST_CLR: begin
                if (host_act_s) begin
                    state_nxt_s = ST_CLR;
                end else if (iEN) begin
                    timer_nxt_s = iPERIOD;
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Sequencer-side port drive and record outputs decoded from the state
    always_comb begin
        seq_we_s   = {WE_WIDTH{1'b0}};
        seq_re_s   = {RE_WIDTH{1'b0}};
        seq_data_s = 8'h00;
        valid_s    = 1'b0;
        busy_s     = 1'b1;
        case (state_r)
            ST_IDLE: begin
                busy_s = 1'b0;
            end
            ST_WAIT: begin
                busy_s = 1'b0;
            end
            ST_RD_L: begin
                seq_re_s = RE_ONE << {slot_r, 1'b0};
            end
            ST_RD_H: begin
                seq_re_s = RE_ONE << {slot_r, 1'b1};
            end
            ST_PUSH: begin
                valid_s = 1'b1;
            end
            ST_CLR: begin
                seq_we_s   = WE_ONE;
                seq_data_s = 8'h01;
            end
            default: begin
                busy_s = 1'b0;
            end
        endcase
    end

    // Port arbitration: host accesses pass straight through and win over the sequencer
    always_comb begin
        if (host_act_s) begin
            oWE_BIT = iH_WE_BIT;
            oRE_BIT = iH_RE_BIT;
            oDATA   = iH_DATA;
            oH_RD   = iRD;
        end else begin
            oWE_BIT = seq_we_s;
            oRE_BIT = seq_re_s;
            oDATA   = seq_data_s;
            oH_RD   = 8'h00;
        end
    end

    // Record interface; index and value read as zero outside a record
    always_comb begin
        oVALID = valid_s;
        oBUSY  = busy_s;
        if (valid_s) begin
            oIDX = slot_r;
            oCNT = cnt_r;
        end else begin
            oIDX = 3'd0;
            oCNT = {C_CNT_WH{1'b0}};
        end
    end

    assign oSCANS = scans_r;

endmodule
